// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: owner of the register file write port (we3/wa3/wd3).
// After reset it optionally clears X0..X30, then round-robins the port
// between core writeback (A) and the debug/loader port (B).
// Writes aimed at the zero register are accepted but discarded and counted.
// Optional feature macro: REGFILE_INIT_EN enables the post-reset clear sequence;
// without it the scheduler comes out of reset directly in RUN.
module regfile_wr_sched #(
    parameter int N_REGS   = 32,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31,
    localparam int AW      = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [AW-1:0]     a_wa,
    input  logic [DATA_W-1:0] a_wd,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [AW-1:0]     b_wa,
    input  logic [DATA_W-1:0] b_wd,
    output logic              b_ready,
    output logic              we3,
    output logic [AW-1:0]     wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              init_busy,
    output logic              pend_valid,
    output logic [AW-1:0]     pend_wa,
    output logic [7:0]        drop_cnt
);

    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {RR_A, RR_B} rr_t;

    typedef struct packed {
        logic [AW-1:0]     wa;
        logic [DATA_W-1:0] wd;
    } wr_req_t;

`ifdef REGFILE_INIT_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = RUN;
`endif

    state_t            state, state_nx;
    rr_t               rr, rr_nx;
    logic [AW-1:0]     cnt, cnt_nx;
    logic              we3_nx;
    logic [AW-1:0]     wa3_nx;
    logic [DATA_W-1:0] wd3_nx;
    logic [7:0]        drop_nx;
    logic              a_acc, b_acc;
    wr_req_t           win;

    // Readiness depends only on the other side's valid and the rr pointer,
    // never on our own valid, so a requester may look at ready before valid.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset && state == RUN) begin
            a_ready = !b_valid || (rr == RR_A);
            b_ready = !a_valid || (rr == RR_B);
        end
        a_acc = a_valid && a_ready;
        b_acc = b_valid && b_ready;
        win   = a_acc ? '{wa: a_wa, wd: a_wd} : '{wa: b_wa, wd: b_wd};
    end

    // Next-state and next-output logic for the clear loop and the arbiter.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rr_nx    = rr;
        we3_nx   = 1'b0;
        wa3_nx   = wa3;
        wd3_nx   = wd3;
        drop_nx  = drop_cnt;
        case (state)
            INIT: begin
                we3_nx = 1'b1;
                wa3_nx = cnt;
                wd3_nx = '0;
                cnt_nx = cnt + 1'b1;
                // The last clear (X30) is issued on the same edge we leave INIT,
                // so a grant in the next cycle lands right behind it.
                if (cnt == AW'(N_REGS - 2))
                    state_nx = RUN;
            end
            RUN: begin
                if (a_acc || b_acc) begin
                    wa3_nx = win.wa;
                    wd3_nx = win.wd;
                    rr_nx  = a_acc ? RR_B : RR_A;
                    if (win.wa == AW'(ZERO_REG)) begin
                        if (drop_cnt != 8'hFF)
                            drop_nx = drop_cnt + 8'd1;
                    end else begin
                        we3_nx = 1'b1;
                    end
                end
            end
            default: state_nx = RST_STATE;
        endcase
    end

    // State and output registers; reset wins over any acceptance on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RST_STATE;
            cnt      <= '0;
            rr       <= RR_A;
            we3      <= 1'b0;
            wa3      <= '0;
            wd3      <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rr       <= rr_nx;
            we3      <= we3_nx;
            wa3      <= wa3_nx;
            wd3      <= wd3_nx;
            drop_cnt <= drop_nx;
        end
    end

    assign init_busy  = reset || (state == INIT);
    assign pend_valid = we3;
    assign pend_wa    = wa3;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench for regfile_wr_sched: behavioural model + per-cycle compare,
// directed scenarios and randomized traffic; a bench-side register file is fed
// from the DUT write port to check end-to-end write results.
module tb_regfile_wr_sched;

`ifdef REGFILE_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_wa = '0, b_wa = '0;
    logic [63:0] a_wd = '0, b_wd = '0;
    logic        a_ready, b_ready;
    logic        we3, init_busy, pend_valid;
    logic [4:0]  wa3, pend_wa;
    logic [63:0] wd3;
    logic [7:0]  drop_cnt;

    regfile_wr_sched dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd), .a_ready(a_ready),
        .b_valid(b_valid), .b_wa(b_wa), .b_wd(b_wd), .b_ready(b_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .init_busy(init_busy),
        .pend_valid(pend_valid), .pend_wa(pend_wa), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit acc_a, acc_b;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register file fed by the DUT port; X31 always reads zero, Xi powers up as i.
    logic [63:0] rf_dut [32];
    initial for (int i = 0; i < 32; i++) rf_dut[i] = 64'(i);
    always @(posedge clk) if (we3 && wa3 != 5'd31) rf_dut[wa3] = wd3;

    function automatic logic [63:0] rd(input int a);
        return (a == 31) ? 64'd0 : rf_dut[a];
    endfunction

    // Behavioural model: what the port must show after each edge.
    bit          m_clear = 1'b0;   // still issuing the clear writes
    int          m_issued = 0;     // clear writes issued so far
    bit          m_turn_b = 1'b0;  // B has priority on the next contended cycle
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [63:0] m_wd = '0;
    int          m_drop = 0;
    bit          g_a, g_b;
    logic [4:0]  g_wa;

    always @(posedge clk) begin
        if (reset) begin
            m_clear = INIT_EN; m_issued = 0; m_turn_b = 1'b0;
            m_we = 1'b0; m_wa = '0; m_wd = '0; m_drop = 0;
        end else if (m_clear) begin
            m_we = 1'b1; m_wa = 5'(m_issued); m_wd = '0;
            m_issued++;
            if (m_issued == 31) m_clear = 1'b0;
        end else begin
            g_a = a_valid && (!b_valid || !m_turn_b);
            g_b = b_valid && !g_a;
            if (g_a || g_b) begin
                g_wa = g_a ? a_wa : b_wa;
                m_wa = g_wa;
                m_wd = g_a ? a_wd : b_wd;
                m_we = (g_wa != 5'd31);
                if (g_wa == 5'd31 && m_drop < 255) m_drop++;
                m_turn_b = g_a;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("init_busy", 64'(init_busy), 64'(reset || m_clear));
            chk("a_ready", 64'(a_ready), 64'(!reset && !m_clear && (!b_valid || !m_turn_b)));
            chk("b_ready", 64'(b_ready), 64'(!reset && !m_clear && (!a_valid || m_turn_b)));
            chk("we3", 64'(we3), 64'(m_we));
            chk("wa3", 64'(wa3), 64'(m_wa));
            chk("wd3", wd3, m_wd);
            chk("pend_valid", 64'(pend_valid), 64'(m_we));
            chk("pend_wa", 64'(pend_wa), 64'(m_wa));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        end
    end

    // One cycle: sample acceptance before the edge, return just after it.
    task automatic step();
        @(negedge clk);
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
        @(posedge clk);
        #1;
    endtask

    // Watch a clear sequence: count write cycles and check address order.
    task automatic clear_run(input string nm);
        int  n = 0;
        bit  ok = 1'b1;
        repeat (34) begin
            @(negedge clk);
            if (we3) begin
                if (int'(wa3) != n || wd3 != 64'd0) ok = 1'b0;
                n++;
            end
        end
        chk(nm, 64'(n), 64'd31);
        chk({nm, "_order"}, 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    logic [5:0] gseq;
    int ai, bi, n12;

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_busy", 64'(init_busy), 64'd1);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1;

        if (INIT_EN) begin
            reset = 1'b0;
            clear_run("clear");
            for (int i = 0; i < 31; i++) chk("clr_reg", rd(i), 64'd0);
            chk("xzr", rd(31), 64'd0);
        end else begin
            a_valid = 1'b1; a_wa = 5'd3; a_wd = 64'h33;
            reset = 1'b0;
            step();
            chk("first_acc", 64'(acc_a), 64'd1);
            a_valid = 1'b0;
            @(negedge clk);
            chk("first_we3", 64'(we3), 64'd1);
            chk("first_wa3", 64'(wa3), 64'd3);
            @(posedge clk); #1;
            chk("first_x3", rd(3), 64'h33);
            chk("keep_x4", rd(4), 64'd4);
        end

        // Single requester A
        a_valid = 1'b1; a_wa = 5'd5; a_wd = 64'hDEADBEEF_DEADBEEF;
        step();
        chk("single_acc", 64'(acc_a), 64'd1);
        a_valid = 1'b0;
        @(negedge clk);
        chk("single_we3", 64'(we3), 64'd1);
        chk("single_wa3", 64'(wa3), 64'd5);
        @(posedge clk); #1;
        chk("single_x5", rd(5), 64'hDEADBEEF_DEADBEEF);

        // B alone, hands priority back to A
        b_valid = 1'b1; b_wa = 5'd20; b_wd = 64'h20;
        step();
        chk("b_acc", 64'(acc_b), 64'd1);
        b_valid = 1'b0;

        // Contention: A to X1.., B to X10..
        gseq = '0; ai = 0; bi = 0;
        a_valid = 1'b1; b_valid = 1'b1;
        a_wa = 5'd1;  a_wd = 64'hA0;
        b_wa = 5'd10; b_wd = 64'hB0;
        repeat (6) begin
            step();
            chk("cont_one", 64'(acc_a ^ acc_b), 64'd1);
            gseq = {gseq[4:0], acc_a};
            if (acc_a) ai++;
            if (acc_b) bi++;
            a_wa = 5'(1 + ai);  a_wd = 64'hA0 + 64'(ai);
            b_wa = 5'(10 + bi); b_wd = 64'hB0 + 64'(bi);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("cont_seq", 64'(gseq), 64'b101010);
        chk("cont_a", 64'(ai), 64'd3);
        chk("cont_b", 64'(bi), 64'd3);
        step(); step();
        chk("cont_x1", rd(1), 64'hA0);
        chk("cont_x3", rd(3), 64'hA2);
        chk("cont_x12", rd(12), 64'hB2);
        chk("x20", rd(20), 64'h20);

        // Zero-register writes
        b_valid = 1'b1; b_wa = 5'd31; b_wd = 64'h1;
        step();
        chk("zr_acc", 64'(acc_b), 64'd1);
        b_valid = 1'b0;
        @(negedge clk);
        chk("zr_we3", 64'(we3), 64'd0);
        chk("zr_drop1", 64'(drop_cnt), 64'd1);
        @(posedge clk); #1;
        b_valid = 1'b1;
        repeat (300) step();
        b_valid = 1'b0;
        @(negedge clk);
        chk("zr_sat", 64'(drop_cnt), 64'd255);
        chk("model_sat", 64'(m_drop), 64'd255);
        chk("zr_xzr", rd(31), 64'd0);
        @(posedge clk); #1;

        // Randomized traffic; pending requests hold until accepted
        repeat (500) begin
            step();
            if (!a_valid || acc_a) begin
                a_valid = 1'($urandom_range(0, 1));
                a_wa = 5'($urandom_range(0, 31));
                a_wd = {$urandom, $urandom};
            end
            if (!b_valid || acc_b) begin
                b_valid = 1'($urandom_range(0, 1));
                b_wa = 5'($urandom_range(0, 31));
                b_wd = {$urandom, $urandom};
            end
        end

        // Reset mid-RUN with both requesters valid
        a_valid = 1'b1; a_wa = 5'd7; a_wd = 64'h7;
        b_valid = 1'b1; b_wa = 5'd8; b_wd = 64'h8;
        reset = 1'b1;
        step();
        chk("rst_noacc", 64'(acc_a | acc_b), 64'd0);
        @(negedge clk);
        chk("rst_run_we3", 64'(we3), 64'd0);
        chk("rst_run_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;

        if (INIT_EN) begin
            // Reset in the middle of the clear loop
            reset = 1'b0;
            n12 = 0;
            for (int i = 0; i < 20 && n12 < 12; i++) begin
                @(negedge clk);
                if (we3) n12++;
            end
            chk("mid_init_cnt", 64'(n12), 64'd12);
            @(posedge clk); #1;
            reset = 1'b1;
            step(); step();
            chk("mid_init_we3", 64'(we3), 64'd0);
            reset = 1'b0;
            clear_run("restart");
        end else begin
            reset = 1'b0;
            repeat (3) step();
        end

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
